hazard_stall_ctrl: RTL and testbench

Pipeline sequencing controller for the five-stage CPU. It decides each cycle whether PC, IF/ID and ID/EX advance, stall, bubble or flush. Sources are load-use hazards against the ID/EX register, taken branches resolved in ID, and multi-cycle data-memory accesses in MEM. It also keeps a memory-wait watchdog and saturating stall/flush event counters for debug.

---
 rtl/hazard_stall_ctrl_if.sv | 37 +++
 rtl/hazard_stall_ctrl.sv | 112 +++++++++++
 tb/tb_hazard_stall_ctrl.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/hazard_stall_ctrl_if.sv
// rtl/hazard_stall_ctrl_if.sv - hazard/stall controller signal bundle
interface hazard_stall_ctrl_if #(
    parameter int CNT_WIDTH = 16
);
    logic [4:0]           ID_RSaddr_i;
    logic [4:0]           ID_RTaddr_i;
    logic [4:0]           EX_RDaddr_i;
    logic                 EX_MemRead_i;
    logic                 branch_taken_i;
    logic                 mem_req_i;
    logic                 mem_ack_i;
    logic                 PCWrite_o;
    logic                 IFID_write_o;
    logic                 IFID_flush_o;
    logic                 IDEX_bubble_o;
    logic                 pipe_hold_o;
    logic                 err_o;
    logic [1:0]           state_o;
    logic [CNT_WIDTH-1:0] stall_cnt_o;
    logic [CNT_WIDTH-1:0] flush_cnt_o;

    // Pipeline side: supplies hazard sources, consumes stage enables.
    modport master (
        output ID_RSaddr_i, ID_RTaddr_i, EX_RDaddr_i, EX_MemRead_i,
               branch_taken_i, mem_req_i, mem_ack_i,
        input  PCWrite_o, IFID_write_o, IFID_flush_o, IDEX_bubble_o,
               pipe_hold_o, err_o, state_o, stall_cnt_o, flush_cnt_o
    );

    // Controller side.
    modport slave (
        input  ID_RSaddr_i, ID_RTaddr_i, EX_RDaddr_i, EX_MemRead_i,
               branch_taken_i, mem_req_i, mem_ack_i,
        output PCWrite_o, IFID_write_o, IFID_flush_o, IDEX_bubble_o,
               pipe_hold_o, err_o, state_o, stall_cnt_o, flush_cnt_o
    );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - pipeline stall/flush sequencer with memory watchdog
module hazard_stall_ctrl #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_WIDTH   = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    hazard_stall_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_MEM_WAIT = 2'b01,
        ST_ERROR    = 2'b10
    } state_t;

    state_t               state_q, state_d;
    logic [9:0]           wait_cnt_q, wait_cnt_d;
    logic [CNT_WIDTH-1:0] stall_cnt_q, flush_cnt_q;

    logic load_use, mem_stall;
    logic pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold;
    // Un-acked cycles including the current one, for the watchdog compare.
    logic [10:0] wait_now;

    assign load_use  = bus.EX_MemRead_i && (bus.EX_RDaddr_i != 5'd0) &&
                       ((bus.EX_RDaddr_i == bus.ID_RSaddr_i) ||
                        (bus.EX_RDaddr_i == bus.ID_RTaddr_i));
    assign mem_stall = bus.mem_req_i && !bus.mem_ack_i;
    assign wait_now  = (state_q == ST_RUN) ? 11'd1 : ({1'b0, wait_cnt_q} + 11'd1);

    // Next-state and enable decode; reset forces a safe bubble pattern.
    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        pipe_hold   = 1'b0;
        case (state_q)
            ST_RUN, ST_MEM_WAIT: begin
                if (mem_stall) begin
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    pipe_hold  = 1'b1;
                    if (wait_now == 11'(MEM_TIMEOUT)) begin
                        state_d = ST_ERROR;
                    end else begin
                        state_d    = ST_MEM_WAIT;
                        wait_cnt_d = wait_now[9:0];
                    end
                end else begin
                    state_d    = ST_RUN;
                    wait_cnt_d = 10'd0;
                    if (load_use) begin
                        pc_write    = 1'b0;
                        ifid_write  = 1'b0;
                        idex_bubble = 1'b1;
                    end else if (bus.branch_taken_i) begin
                        ifid_flush = 1'b1;
                    end
                end
            end
            default: begin
                pc_write   = 1'b0;
                ifid_write = 1'b0;
                pipe_hold  = 1'b1;
            end
        endcase
        if (rst_i) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            ifid_flush  = 1'b0;
            idex_bubble = 1'b1;
            pipe_hold   = 1'b0;
        end
    end

    // FSM state and watchdog counter.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_RUN;
            wait_cnt_q <= 10'd0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Saturating debug counters; ERROR cycles are not stalls worth counting.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (!pc_write && (state_q != ST_ERROR) && (stall_cnt_q != '1))
                stall_cnt_q <= stall_cnt_q + 1'b1;
            if (ifid_flush && (flush_cnt_q != '1))
                flush_cnt_q <= flush_cnt_q + 1'b1;
        end
    end

    assign bus.PCWrite_o     = pc_write;
    assign bus.IFID_write_o  = ifid_write;
    assign bus.IFID_flush_o  = ifid_flush;
    assign bus.IDEX_bubble_o = idex_bubble;
    assign bus.pipe_hold_o   = pipe_hold;
    assign bus.err_o         = (state_q == ST_ERROR);
    assign bus.state_o       = state_q;
    assign bus.stall_cnt_o   = stall_cnt_q;
    assign bus.flush_cnt_o   = flush_cnt_q;
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb/tb_hazard_stall_ctrl.sv - directed self-checking bench for hazard_stall_ctrl
module tb_hazard_stall_ctrl;
    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk_i = ~clk_i;

    hazard_stall_ctrl_if #(.CNT_WIDTH(4)) bus ();

    hazard_stall_ctrl #(.MEM_TIMEOUT(4), .CNT_WIDTH(4)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic set_in(input logic mr, input logic [4:0] rd, input logic [4:0] rs,
                          input logic [4:0] rt, input logic br, input logic rq, input logic ak);
        @(negedge clk_i);
        bus.EX_MemRead_i   = mr;
        bus.EX_RDaddr_i    = rd;
        bus.ID_RSaddr_i    = rs;
        bus.ID_RTaddr_i    = rt;
        bus.branch_taken_i = br;
        bus.mem_req_i      = rq;
        bus.mem_ack_i      = ak;
        #1;
    endtask

    task automatic idle();
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        bus.EX_MemRead_i = 0; bus.EX_RDaddr_i = 0; bus.ID_RSaddr_i = 0;
        bus.ID_RTaddr_i = 0; bus.branch_taken_i = 0; bus.mem_req_i = 0; bus.mem_ack_i = 0;
        #3;
        // Reset values
        chk("rst_pcwrite", bus.PCWrite_o, 0);
        chk("rst_ifid_write", bus.IFID_write_o, 0);
        chk("rst_flush", bus.IFID_flush_o, 0);
        chk("rst_bubble", bus.IDEX_bubble_o, 1);
        chk("rst_hold", bus.pipe_hold_o, 0);
        chk("rst_state", bus.state_o, 0);
        chk("rst_err", bus.err_o, 0);
        chk("rst_stall_cnt", bus.stall_cnt_o, 0);
        chk("rst_flush_cnt", bus.flush_cnt_o, 0);
        @(negedge clk_i); rst_i = 1'b0;

        idle();
        chk("idle_pcwrite", bus.PCWrite_o, 1);
        chk("idle_bubble", bus.IDEX_bubble_o, 0);

        // Load-use on rs
        set_in(1'b1, 5'd5, 5'd5, 5'd7, 1'b0, 1'b0, 1'b0);
        chk("lu_pcwrite", bus.PCWrite_o, 0);
        chk("lu_ifid_write", bus.IFID_write_o, 0);
        chk("lu_bubble", bus.IDEX_bubble_o, 1);
        chk("lu_hold", bus.pipe_hold_o, 0);
        // Load to $0 never stalls
        set_in(1'b1, 5'd0, 5'd3, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("lu_stall_cnt", bus.stall_cnt_o, 1);
        chk("r0_pcwrite", bus.PCWrite_o, 1);
        chk("r0_bubble", bus.IDEX_bubble_o, 0);

        // Memory access acked 3 cycles after request
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        chk("mw0_state", bus.state_o, 0);
        chk("mw0_hold", bus.pipe_hold_o, 1);
        chk("mw0_pcwrite", bus.PCWrite_o, 0);
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        chk("mw1_state", bus.state_o, 1);
        chk("mw1_hold", bus.pipe_hold_o, 1);
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        chk("mw2_state", bus.state_o, 1);
        chk("mw2_hold", bus.pipe_hold_o, 1);
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1);
        chk("mw3_state", bus.state_o, 1);
        chk("mw3_hold", bus.pipe_hold_o, 0);
        chk("mw3_pcwrite", bus.PCWrite_o, 1);
        idle();
        chk("mw_done_state", bus.state_o, 0);
        chk("mw_stall_cnt", bus.stall_cnt_o, 4);

        // All three events together: memory stall wins
        set_in(1'b1, 5'd9, 5'd9, 5'd9, 1'b1, 1'b1, 1'b0);
        chk("sim_hold", bus.pipe_hold_o, 1);
        chk("sim_flush", bus.IFID_flush_o, 0);
        chk("sim_bubble", bus.IDEX_bubble_o, 0);
        // Request drops in MEM_WAIT: acts as ack, branch now honoured
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        chk("sim_flush_cnt0", bus.flush_cnt_o, 0);
        chk("br_state", bus.state_o, 1);
        chk("br_flush", bus.IFID_flush_o, 1);
        chk("br_pcwrite", bus.PCWrite_o, 1);
        idle();
        chk("br_flush_cnt", bus.flush_cnt_o, 1);
        chk("br_ret_state", bus.state_o, 0);
        chk("br_stall_cnt", bus.stall_cnt_o, 5);

        // Ack in the T-th un-acked-window cycle still succeeds
        for (int i = 0; i < 3; i++) set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1);
        chk("ackT_state", bus.state_o, 1);
        chk("ackT_hold", bus.pipe_hold_o, 0);
        idle();
        chk("ackT_ret_state", bus.state_o, 0);
        chk("ackT_err", bus.err_o, 0);
        chk("ackT_stall_cnt", bus.stall_cnt_o, 8);

        // Watchdog: 4 un-acked cycles, then ERROR
        for (int i = 0; i < 4; i++) set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        chk("wd4_state", bus.state_o, 1);
        chk("wd4_err", bus.err_o, 0);
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        chk("wd_state", bus.state_o, 2);
        chk("wd_err", bus.err_o, 1);
        chk("wd_pcwrite", bus.PCWrite_o, 0);
        chk("wd_hold", bus.pipe_hold_o, 1);
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        chk("wd_sticky_state", bus.state_o, 2);
        chk("wd_sticky_err", bus.err_o, 1);
        chk("wd_stall_cnt", bus.stall_cnt_o, 12);
        chk("wd_flush", bus.IFID_flush_o, 0);
        #1 rst_i = 1'b1;
        #1;
        chk("arst_state", bus.state_o, 0);
        chk("arst_err", bus.err_o, 0);
        chk("arst_stall_cnt", bus.stall_cnt_o, 0);
        @(negedge clk_i); rst_i = 1'b0;

        // Saturation with 4-bit counters
        for (int i = 0; i < 15; i++) set_in(1'b1, 5'd4, 5'd1, 5'd4, 1'b0, 1'b0, 1'b0);
        idle();
        chk("sat15_stall_cnt", bus.stall_cnt_o, 15);
        for (int i = 0; i < 5; i++) set_in(1'b1, 5'd4, 5'd1, 5'd4, 1'b0, 1'b0, 1'b0);
        idle();
        chk("sat20_stall_cnt", bus.stall_cnt_o, 15);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
